// File: rtl/hex_display_pkg.sv
// Shared types and the 7-segment code table for the hex display controller.
// Segment words are bit6..0 = g..a, active-low.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t seg_code(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_display_ctrl_seg7_enc.sv
// Combinational nibble-to-segment encoder with a blank override.
// One instance per digit in static mode, a single shared one in scan mode.
module seg7_enc
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output seg_t       o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : seg_code(i_nib);

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex 7-segment controller: handshake in, double buffer, static or scan out.
// Define HEX_DISPLAY_DP_EN to add buffered decimal points (dp_i, dp_o, dp_seg_o).
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_EN   = 0,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  blank_lz_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
`ifdef HEX_DISPLAY_DP_EN
  input  logic [DIGITS-1:0]     dp_i,
  output logic [DIGITS-1:0]     dp_o,
  output logic                  dp_seg_o,
`endif
  output logic [7*DIGITS-1:0]   hex_o,
  output seg_t                  seg_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);

  logic [4*DIGITS-1:0] r_pend;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_full;
  logic                r_phase;
  logic [BW-1:0]       r_blink_cnt;
  logic                w_take;
  logic                w_commit;
  logic [DIGITS-1:0]   w_lz;
  logic [DIGITS-1:0]   w_blank;
`ifdef HEX_DISPLAY_DP_EN
  logic [DIGITS-1:0]   r_pend_dp;
  logic [DIGITS-1:0]   r_disp_dp;
`endif

  assign ready_o = ~r_full;
  assign w_take  = valid_i & ~r_full;

  // New data may land in pending on the same edge the old pending commits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend <= '0;
      r_disp <= '0;
      r_full <= 1'b0;
`ifdef HEX_DISPLAY_DP_EN
      r_pend_dp <= '0;
      r_disp_dp <= '0;
`endif
    end else begin
      if (w_commit) begin
        r_disp <= r_pend;
`ifdef HEX_DISPLAY_DP_EN
        r_disp_dp <= r_pend_dp;
`endif
      end
      if (w_take) begin
        r_pend <= data_i;
        r_full <= 1'b1;
`ifdef HEX_DISPLAY_DP_EN
        r_pend_dp <= dp_i;
`endif
      end else if (w_commit) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Leading-zero run measured from the top digit down; digit 0 never joins it.
  always_comb begin
    logic z;
    z    = 1'b1;
    w_lz = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z       = z & (r_disp[4*k +: 4] == 4'd0);
      w_lz[k] = z;
    end
    w_blank = (w_lz & {DIGITS{blank_lz_i}})
            | (blink_mask_i & {DIGITS{r_phase}});
  end

  if (SCAN_EN == 0) begin : g_static

    seg_t w_seg [DIGITS];

    for (genvar k = 0; k < DIGITS; k++) begin : g_enc
      seg7_enc u_enc (
        .i_nib   (r_disp[4*k +: 4]),
        .i_blank (w_blank[k]),
        .o_seg   (w_seg[k])
      );
    end

    assign w_commit = r_full;
    assign seg_o    = SEG_BLANK;
    assign an_o     = '1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        hex_o <= '1;
      end else begin
        for (int k = 0; k < DIGITS; k++) begin
          hex_o[7*k +: 7] <= w_seg[k];
        end
      end
    end

`ifdef HEX_DISPLAY_DP_EN
    assign dp_seg_o = 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) dp_o <= '1;
      else          dp_o <= ~(r_disp_dp & ~w_blank);
    end
`endif

  end else begin : g_scan

    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_idx;
    logic          w_tick;
    logic          w_wrap;
    logic [3:0]    w_nib;
    logic          w_sel_blank;
    seg_t          w_seg;
`ifdef HEX_DISPLAY_DP_EN
    logic          w_sel_dp;
`endif

    assign w_tick   = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_wrap   = (r_idx == IW'(DIGITS - 1));
    // Commit only as the index wraps so a frame never mixes two values.
    assign w_commit = r_full & w_tick & w_wrap;
    assign hex_o    = '1;

    always_comb begin
      w_nib       = r_disp[3:0];
      w_sel_blank = w_blank[0];
`ifdef HEX_DISPLAY_DP_EN
      w_sel_dp    = r_disp_dp[0];
`endif
      for (int k = 1; k < DIGITS; k++) begin
        if (r_idx == IW'(k)) begin
          w_nib       = r_disp[4*k +: 4];
          w_sel_blank = w_blank[k];
`ifdef HEX_DISPLAY_DP_EN
          w_sel_dp    = r_disp_dp[k];
`endif
        end
      end
    end

    seg7_enc u_enc (
      .i_nib   (w_nib),
      .i_blank (w_sel_blank),
      .o_seg   (w_seg)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_scan_cnt <= '0;
        r_idx      <= '0;
        seg_o      <= SEG_BLANK;
        an_o       <= '1;
`ifdef HEX_DISPLAY_DP_EN
        dp_seg_o   <= 1'b1;
`endif
      end else begin
        r_scan_cnt <= w_tick ? '0 : r_scan_cnt + SW'(1);
        if (w_tick) begin
          r_idx <= w_wrap ? '0 : r_idx + IW'(1);
        end
        seg_o <= w_seg;
        an_o  <= ~(DIGITS'(1) << r_idx);
`ifdef HEX_DISPLAY_DP_EN
        dp_seg_o <= ~(w_sel_dp & ~w_sel_blank);
`endif
      end
    end

`ifdef HEX_DISPLAY_DP_EN
    assign dp_o = '1;
`endif

  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: a static instance and a scan instance share clock and reset.
// Expected displays come from a local code table and are queued when data is sent.
module tb_hex_display_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] TB_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_lz;
  logic [3:0]  s_mask;
  logic [27:0] s_hex;
  logic [6:0]  s_seg;
  logic [3:0]  s_an;

  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_lz;
  logic [3:0]  m_mask;
  logic [27:0] m_hex;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;

  logic [27:0] sq[$];
  logic [27:0] mq[$];

  hex_display_ctrl #(
    .DIGITS(4), .SCAN_EN(0), .SCAN_DIV(4), .BLINK_DIV(8)
  ) u_static (
    .clk_i(clk), .rst_n_i(rst_n),
    .data_i(s_data), .valid_i(s_valid), .ready_o(s_ready),
    .blank_lz_i(s_lz), .blink_mask_i(s_mask),
    .hex_o(s_hex), .seg_o(s_seg), .an_o(s_an)
  );

  hex_display_ctrl #(
    .DIGITS(4), .SCAN_EN(1), .SCAN_DIV(4), .BLINK_DIV(64)
  ) u_scan (
    .clk_i(clk), .rst_n_i(rst_n),
    .data_i(m_data), .valid_i(m_valid), .ready_o(m_ready),
    .blank_lz_i(m_lz), .blink_mask_i(m_mask),
    .hex_o(m_hex), .seg_o(m_seg), .an_o(m_an)
  );

  function automatic logic [27:0] exp_hex(input logic [15:0] v, input logic lz);
    logic [27:0] r;
    logic        z;
    logic [3:0]  n;
    z = 1'b1;
    r = '0;
    for (int k = 3; k >= 0; k--) begin
      n = v[4*k +: 4];
      z = z && (n == 4'd0);
      r[7*k +: 7] = (lz && z && k > 0) ? 7'h7F : TB_SEG[n];
    end
    return r;
  endfunction

  task automatic s_send(input logic [15:0] v);
    int n;
    n = 0;
    s_data  = v;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL s_send_timeout: ready_o got %b, want 1", s_ready);
    end
    sq.push_back(exp_hex(v, s_lz));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    s_data = '0; s_valid = 1'b0; s_lz = 1'b0; s_mask = '0;
    m_data = '0; m_valid = 1'b0; m_lz = 1'b0; m_mask = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_hex !== {4{7'h7F}}) begin
      errors++; $display("FAIL reset_hex: got %h, want %h", s_hex, {4{7'h7F}});
    end
    checks++;
    if (s_ready !== 1'b1 || m_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b%b, want 11", s_ready, m_ready);
    end
    checks++;
    if (m_seg !== 7'h7F || m_an !== 4'hF) begin
      errors++; $display("FAIL reset_scan: got %h/%b, want 7f/1111", m_seg, m_an);
    end
    checks++;
    if (s_seg !== 7'h7F || s_an !== 4'hF || m_hex !== {4{7'h7F}}) begin
      errors++;
      $display("FAIL reset_unused_outs: got %h/%b/%h, want 7f/1111/%h",
               s_seg, s_an, m_hex, {4{7'h7F}});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_hex !== {4{7'h40}}) begin
      errors++; $display("FAIL idle_hex: got %h, want %h", s_hex, {4{7'h40}});
    end
    checks++;
    if (m_an !== 4'b1110 || m_seg !== 7'h40) begin
      errors++; $display("FAIL idle_scan: got %h/%b, want 40/1110", m_seg, m_an);
    end
    s_lz = 1'b1;
    @(negedge clk);
    checks++;
    if (s_hex !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      errors++;
      $display("FAIL idle_lz: got %h, want %h", s_hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
  endtask

  task automatic test_static_load();
    logic [27:0] e;
    s_lz = 1'b1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready_idle: got %b, want 1", s_ready);
    end
    s_send(16'h00A5);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL load_ready_busy: got %b, want 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready_free: got %b, want 1", s_ready);
    end
    @(negedge clk);
    e = sq.pop_front();
    checks++;
    if (s_hex !== e) begin
      errors++; $display("FAIL load_hex: got %h, want %h", s_hex, e);
    end
    checks++;
    if (s_hex !== {7'h7F, 7'h7F, 7'h08, 7'h12}) begin
      errors++;
      $display("FAIL load_hex_table: got %h, want %h", s_hex, {7'h7F, 7'h7F, 7'h08, 7'h12});
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] e;
    s_lz = 1'b0;
    s_send(16'h1234);
    s_send(16'hFFFF);
    e = sq.pop_front();
    checks++;
    if (s_hex !== e) begin
      errors++; $display("FAIL b2b_first: got %h, want %h", s_hex, e);
    end
    repeat (2) @(negedge clk);
    e = sq.pop_front();
    checks++;
    if (s_hex !== e) begin
      errors++; $display("FAIL b2b_second: got %h, want %h", s_hex, e);
    end
    checks++;
    if (s_hex !== {4{7'h0E}}) begin
      errors++; $display("FAIL b2b_final: got %h, want %h", s_hex, {4{7'h0E}});
    end
  endtask

  task automatic test_blink();
    logic [27:0] e;
    logic [6:0]  prev;
    int          run;
    int          trans;
    s_lz   = 1'b0;
    s_mask = 4'b0000;
    s_send(16'h0007);
    repeat (2) @(negedge clk);
    e = sq.pop_front();
    checks++;
    if (s_hex !== e) begin
      errors++; $display("FAIL blink_load: got %h, want %h", s_hex, e);
    end
    s_mask = 4'b0001;
    prev   = s_hex[6:0];
    run    = 0;
    trans  = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (s_hex[27:7] !== {3{7'h40}}) begin
        errors++; $display("FAIL blink_steady: got %h, want %h", s_hex[27:7], {3{7'h40}});
      end
      checks++;
      if (!(s_hex[6:0] === 7'h78 || s_hex[6:0] === 7'h7F)) begin
        errors++; $display("FAIL blink_digit0: got %h, want 78 or 7f", s_hex[6:0]);
      end
      if (s_hex[6:0] !== prev) begin
        if (trans >= 2) begin
          checks++;
          if (run != 8) begin
            errors++; $display("FAIL blink_period: got %0d, want 8", run);
          end
        end
        trans++;
        run  = 1;
        prev = s_hex[6:0];
      end else begin
        run++;
      end
    end
    checks++;
    if (trans < 4) begin
      errors++; $display("FAIL blink_toggles: got %0d, want >= 4", trans);
    end
    s_mask = 4'b0000;
  endtask

  task automatic test_scan();
    logic [3:0]  prev_an;
    logic [27:0] frame;
    logic [27:0] cur_new;
    int          run;
    int          idx;
    int          n;
    bit          first_run;
    bit          have;
    bit          sent;
    bit          new_seen;
    m_lz   = 1'b0;
    m_mask = '0;
    n = 0;
    while (m_an !== 4'b1110 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++; $display("FAIL scan_sync: an_o got %b, want 1110", m_an);
    end
    prev_an   = m_an;
    run       = 1;
    first_run = 1'b1;
    have      = 1'b0;
    sent      = 1'b0;
    new_seen  = 1'b0;
    frame     = '0;
    cur_new   = '0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (m_valid) begin
        m_valid = 1'b0;
        checks++;
        if (m_ready !== 1'b0) begin
          errors++; $display("FAIL scan_ready_busy: got %b, want 0", m_ready);
        end
      end
      if (m_an !== prev_an) begin
        checks++;
        if (m_an !== {prev_an[2:0], prev_an[3]}) begin
          errors++;
          $display("FAIL scan_order: got %b, want %b", m_an, {prev_an[2:0], prev_an[3]});
        end
        if (!first_run) begin
          checks++;
          if (run != 4) begin
            errors++; $display("FAIL scan_dwell: got %0d, want 4", run);
          end
        end
        first_run = 1'b0;
        run       = 1;
        prev_an   = m_an;
        case (m_an)
          4'b1110: idx = 0;
          4'b1101: idx = 1;
          4'b1011: idx = 2;
          4'b0111: idx = 3;
          default: idx = -1;
        endcase
        if (idx >= 0) frame[7*idx +: 7] = m_seg;
        if (idx == 0) have = 1'b1;
        if (idx == 1 && have && !sent) begin
          m_data  = 16'h1234;
          m_valid = 1'b1;
          mq.push_back(exp_hex(16'h1234, m_lz));
          sent = 1'b1;
        end
        if (idx == 3 && have) begin
          checks++;
          if (new_seen) begin
            if (frame !== cur_new) begin
              errors++; $display("FAIL scan_frame_new: got %h, want %h", frame, cur_new);
            end
          end else if (mq.size() != 0 && frame === mq[0]) begin
            cur_new  = mq.pop_front();
            new_seen = 1'b1;
          end else if (frame !== {4{7'h40}}) begin
            errors++; $display("FAIL scan_frame_torn: got %h, want %h", frame, {4{7'h40}});
          end
        end
      end else begin
        run++;
      end
    end
    checks++;
    if (!new_seen || mq.size() != 0) begin
      errors++; $display("FAIL scan_new_frame: seen %0d, want 1", new_seen);
    end
    checks++;
    if (m_ready !== 1'b1) begin
      errors++; $display("FAIL scan_ready_free: got %b, want 1", m_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    n = 0;
    while (m_an !== 4'b1101 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++; $display("FAIL rst_sync: an_o got %b, want 1101", m_an);
    end
    m_data  = 16'hBEEF;
    m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    checks++;
    if (m_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pending_full: got %b, want 0", m_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_seg !== 7'h7F || m_an !== 4'hF) begin
      errors++; $display("FAIL rst_async_scan: got %h/%b, want 7f/1111", m_seg, m_an);
    end
    checks++;
    if (m_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async_ready: got %b, want 1", m_ready);
    end
    checks++;
    if (s_hex !== {4{7'h7F}}) begin
      errors++; $display("FAIL rst_async_static: got %h, want %h", s_hex, {4{7'h7F}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (m_seg !== 7'h40) begin
        errors++; $display("FAIL rst_discard: got %h, want 40", m_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static_load();
    test_back_to_back();
    test_blink();
    test_scan();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
